// File: rtl/latch_tester_if.sv
// Signal bundle between the latch tester, the lab switches/LEDs and the latch under test.
// master = tester side, slave = environment (switches, latch, LEDs).
interface latch_tester_if #(
    parameter int W = 4
);
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

    logic             start;
    logic [W-1:0]     pattern;
    logic             q_in;
    logic             qn_in;
    logic             lat_d;
    logic             lat_g;
    logic             busy;
    logic             done;
    logic             pass;
    logic             err_valid;
    logic [IDX_W-1:0] err_idx;

    modport master (
        input  start, pattern, q_in, qn_in,
        output lat_d, lat_g, busy, done, pass, err_valid, err_idx
    );

    modport slave (
        output start, pattern, q_in, qn_in,
        input  lat_d, lat_g, busy, done, pass, err_valid, err_idx
    );
endinterface

// File: rtl/latch_tester.sv
// Walks a W-bit pattern through a level-sensitive D latch, checking transparency while the
// gate is open and hold after it closes; reports pass / first failing bit index.
module latch_tester #(
    parameter int W        = 4,
    parameter int GATE_CYC = 2,
    parameter int SETTLE   = 3
) (
    input  logic           clk,
    input  logic           rst,
    latch_tester_if.master bus
);
    localparam int IDX_W   = (W > 1) ? $clog2(W) : 1;
    localparam int CNT_MAX = (GATE_CYC > SETTLE) ? GATE_CYC : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_GATE  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]       state;
    logic [W-1:0]     pat_r;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [CNT_W-1:0] cnt;

    logic             q_sync_p0, q_sync_p1;
    logic             qn_sync_p0, qn_sync_p1;

    logic             lat_d_r, lat_g_r, busy_r, done_r, pass_r, err_valid_r;
    logic [IDX_W-1:0] err_idx_r;

    // A bit is good only if q shows the written value and qn its complement.
    function automatic logic bit_ok(input logic q, input logic qn, input logic expected);
        return (q == expected) && (qn == ~expected);
    endfunction

    assign idx_nxt = idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            cnt         <= '0;
            q_sync_p0   <= 1'b0;
            q_sync_p1   <= 1'b0;
            qn_sync_p0  <= 1'b0;
            qn_sync_p1  <= 1'b0;
            lat_d_r     <= 1'b0;
            lat_g_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_valid_r <= 1'b0;
            err_idx_r   <= '0;
        end else begin
            // q/qn arrive asynchronously; two flops before anything looks at them.
            q_sync_p0  <= bus.q_in;
            q_sync_p1  <= q_sync_p0;
            qn_sync_p0 <= bus.qn_in;
            qn_sync_p1 <= qn_sync_p0;
            done_r     <= 1'b0;

            case (state)
                S_IDLE: begin
                    lat_g_r <= 1'b0;
                    if (bus.start) begin
                        pat_r       <= bus.pattern;
                        idx         <= '0;
                        pass_r      <= 1'b1;
                        err_valid_r <= 1'b0;
                        err_idx_r   <= '0;
                        busy_r      <= 1'b1;
                        lat_d_r     <= bus.pattern[0];
                        state       <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    lat_g_r <= 1'b1;
                    cnt     <= CNT_W'(GATE_CYC - 1);
                    state   <= S_GATE;
                end
                S_GATE: begin
                    if (cnt == '0) begin
                        // Gate closes and data flips on the same edge so hold is exercised.
                        lat_g_r <= 1'b0;
                        lat_d_r <= ~pat_r[idx];
                        cnt     <= CNT_W'(SETTLE - 1);
                        state   <= S_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_CHECK: begin
                    if (!bit_ok(q_sync_p1, qn_sync_p1, pat_r[idx])) begin
                        pass_r <= 1'b0;
                        if (!err_valid_r) begin
                            err_valid_r <= 1'b1;
                            err_idx_r   <= idx;
                        end
                    end
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (idx == IDX_W'(W - 1)) begin
                        done_r <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        idx     <= idx_nxt;
                        lat_d_r <= pat_r[idx_nxt];
                        state   <= S_SETUP;
                    end
                end
                S_DONE: begin
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    lat_g_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.lat_d     = lat_d_r;
    assign bus.lat_g     = lat_g_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.err_valid = err_valid_r;
    assign bus.err_idx   = err_idx_r;
endmodule

// File: tb/tb_latch_tester.sv
// Scoreboard bench for latch_tester: a latch model with selectable faults feeds q/qn,
// runs push expected results, a done-triggered monitor pops and compares them.
module tb_latch_tester;
    localparam int W     = 4;
    localparam int IDX_W = 2;
    localparam int RUN_CYC = 33;

    localparam int M_IDEAL  = 0;
    localparam int M_STUCK0 = 1;
    localparam int M_TRANSP = 2;
    localparam int M_QNEQQ  = 3;
    localparam int M_STUCK1 = 4;

    typedef struct {
        int    pass;
        int    ev;
        int    idx;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    latch_tester_if #(.W(W)) bus ();

    latch_tester #(.W(W), .GATE_CYC(2), .SETTLE(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    checks   = 0;
    int    failures = 0;
    int    mode     = M_IDEAL;
    logic  q_lat    = 1'b0;
    logic  mon_en   = 1'b0;
    exp_t  sb[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Latch under test: transparent while gate is high, sampled mid-cycle.
    always @(negedge clk) if (bus.lat_g === 1'b1) q_lat <= bus.lat_d;

    always_comb begin
        bus.q_in  = q_lat;
        bus.qn_in = ~q_lat;
        case (mode)
            M_STUCK0: begin bus.q_in = 1'b0;      bus.qn_in = 1'b1;       end
            M_TRANSP: begin bus.q_in = bus.lat_d; bus.qn_in = ~bus.lat_d; end
            M_QNEQQ:  begin bus.q_in = q_lat;     bus.qn_in = q_lat;      end
            M_STUCK1: begin bus.q_in = 1'b1;      bus.qn_in = 1'b0;       end
            default:  ;
        endcase
    end

    // Monitor: scoreboard on done, busy-length latency, data-stable-while-gated invariant.
    int   bcnt   = 0;
    logic prev_d = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rst) bcnt = 0;
            else if (bus.busy) bcnt++;
            else bcnt = 0;
            if (bus.lat_d !== prev_d) chk("d_change_gate_low", int'(bus.lat_g), 0);
            prev_d = bus.lat_d;
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_pass"},      int'(bus.pass),      e.pass);
                    chk({e.name, "_err_valid"}, int'(bus.err_valid), e.ev);
                    chk({e.name, "_err_idx"},   int'(bus.err_idx),   e.idx);
                    chk({e.name, "_latency"},   bcnt,                RUN_CYC);
                end
            end
        end
    end

    task automatic expect_run(input string name, input int p, input int ev, input int idx);
        exp_t e;
        e.name = name; e.pass = p; e.ev = ev; e.idx = idx;
        sb.push_back(e);
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 of the first run cycle (SETUP).
    task automatic launch(input logic [W-1:0] pat, input int m);
        mode        = m;
        bus.pattern = pat;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("run_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.pattern = '0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        prev_d = 1'b0;
        mon_en = 1'b1;

        chk("rst_lat_d",     int'(bus.lat_d),     0);
        chk("rst_lat_g",     int'(bus.lat_g),     0);
        chk("rst_busy",      int'(bus.busy),      0);
        chk("rst_done",      int'(bus.done),      0);
        chk("rst_pass",      int'(bus.pass),      0);
        chk("rst_err_valid", int'(bus.err_valid), 0);
        chk("rst_err_idx",   int'(bus.err_idx),   0);

        expect_run("ideal_1010", 1, 0, 0);
        launch(4'b1010, M_IDEAL);
        chk("busy_after_accept", int'(bus.busy), 1);
        wait_idle(100);
        repeat (5) @(posedge clk);
        #1;
        chk("pass_held",      int'(bus.pass),      1);
        chk("err_valid_held", int'(bus.err_valid), 0);

        expect_run("stuck0_0110", 0, 1, 1);
        launch(4'b0110, M_STUCK0);
        wait_idle(100);
        chk("err_idx_held", int'(bus.err_idx), 1);

        expect_run("stuck0_0000", 1, 0, 0);
        launch(4'b0000, M_STUCK0);
        wait_idle(100);

        expect_run("stuck1_1101", 0, 1, 1);
        launch(4'b1101, M_STUCK1);
        wait_idle(100);

        expect_run("transp_0001", 0, 1, 0);
        launch(4'b0001, M_TRANSP);
        wait_idle(100);

        expect_run("qneqq_1010", 0, 1, 0);
        launch(4'b1010, M_QNEQQ);
        wait_idle(100);

        // start pulsed again during the gate of bit 2 (run cycle 18) must be ignored
        expect_run("restart_ignored_1100", 1, 0, 0);
        launch(4'b1100, M_IDEAL);
        repeat (17) @(posedge clk);
        #1;
        chk("gate_bit2_open", int'(bus.lat_g), 1);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle(100);
        repeat (40) @(posedge clk);
        #1;
        chk("restart_busy_low", int'(bus.busy), 0);

        // start held high across DONE: a second run follows immediately
        expect_run("held_start_run1_0101", 1, 0, 0);
        expect_run("held_start_run2_0101", 1, 0, 0);
        launch(4'b0101, M_IDEAL);
        bus.start = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle(150);

        // reset in the first HOLD cycle of bit 1 (run cycle 12)
        launch(4'b1010, M_IDEAL);
        repeat (10) @(posedge clk);
        #1;
        chk("gate_bit1_open", int'(bus.lat_g), 1);
        @(posedge clk); #1;
        chk("hold_bit1_gate",  int'(bus.lat_g), 0);
        chk("hold_bit1_d_inv", int'(bus.lat_d), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_lat_g",     int'(bus.lat_g),     0);
        chk("abort_lat_d",     int'(bus.lat_d),     0);
        chk("abort_busy",      int'(bus.busy),      0);
        chk("abort_pass",      int'(bus.pass),      0);
        chk("abort_done",      int'(bus.done),      0);
        chk("abort_err_valid", int'(bus.err_valid), 0);
        rst = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        chk("abort_stays_idle", int'(bus.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
